// File: rtl/ex_branch_scheduler_pkg.sv
// Shared definitions for the branch scheduler: queue geometry, FSM encoding,
// branch command / condition code values and the queue entry layout.
package ex_branch_scheduler_pkg;

    localparam int QUEUE_DEPTH = 4;
    localparam int PTR_W       = 2;
    localparam int CNT_W       = 3;
    localparam logic [CNT_W-1:0] QUEUE_FULL_COUNT = 3'd4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_LOCKED = 1'b1
    } sched_state_t;

    typedef enum logic [4:0] {
        BR_CMD_NOP  = 5'h00,
        BR_CMD_JUMP = 5'h01,
        BR_CMD_CALL = 5'h02,
        BR_CMD_RET  = 5'h03,
        BR_CMD_INTR = 5'h04
    } br_cmd_t;

    typedef enum logic [3:0] {
        BR_CC_AL = 4'h0,
        BR_CC_EQ = 4'h1,
        BR_CC_NE = 4'h2,
        BR_CC_CS = 4'h3,
        BR_CC_CC = 4'h4,
        BR_CC_MI = 4'h5,
        BR_CC_PL = 4'h6
    } br_cc_t;

    typedef struct packed {
        logic [5:0]  tag;
        logic [4:0]  cmd;
        logic [3:0]  cc;
        logic [31:0] source;
        logic [31:0] pc;
        logic [4:0]  flag;
        logic        flag_ready;
        logic [5:0]  flag_tag;
    } br_entry_t;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/ex_branch_sched_queue.sv
// In-order 4-entry circular queue of branch ops with flag wakeup.
// A push whose flag producer is broadcast in the same cycle is stored ready.
module ex_branch_sched_queue
    import ex_branch_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic [5:0]       push_tag,
    input  logic [4:0]       push_cmd,
    input  logic [3:0]       push_cc,
    input  logic [31:0]      push_source,
    input  logic [31:0]      push_pc,
    input  logic             push_flag_ready,
    input  logic [4:0]       push_flag,
    input  logic [5:0]       push_flag_tag,
    input  logic             pop,
    input  logic             wb_valid,
    input  logic [5:0]       wb_tag,
    input  logic [4:0]       wb_flag,
    output logic [CNT_W-1:0] count,
    output logic [5:0]       head_tag,
    output logic [4:0]       head_cmd,
    output logic [3:0]       head_cc,
    output logic [31:0]      head_source,
    output logic [31:0]      head_pc,
    output logic [4:0]       head_flag,
    output logic             head_ready
);

    br_entry_t              entries [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] valid;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    br_entry_t              new_entry;
    logic                   push_wakeup;

    // Build the incoming entry, folding in a same-cycle matching broadcast
    always_comb begin
        push_wakeup          = !push_flag_ready && wb_valid && (wb_tag == push_flag_tag);
        new_entry            = '0;
        new_entry.tag        = push_tag;
        new_entry.cmd        = push_cmd;
        new_entry.cc         = push_cc;
        new_entry.source     = push_source;
        new_entry.pc         = push_pc;
        new_entry.flag_tag   = push_flag_tag;
        new_entry.flag_ready = push_flag_ready || push_wakeup;
        new_entry.flag       = push_wakeup ? wb_flag : push_flag;
    end

    // Queue storage, pointers, occupancy and broadcast wakeup
    always_ff @(posedge clk) begin
        if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (valid[i] && !entries[i].flag_ready && wb_valid &&
                    (wb_tag == entries[i].flag_tag)) begin
                    entries[i].flag_ready <= 1'b1;
                    entries[i].flag       <= wb_flag;
                end
            end
            if (push) begin
                entries[tail] <= new_entry;
                valid[tail]   <= 1'b1;
                tail          <= ptr_next(tail);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= ptr_next(head);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_tag    = entries[head].tag;
    assign head_cmd    = entries[head].cmd;
    assign head_cc     = entries[head].cc;
    assign head_source = entries[head].source;
    assign head_pc     = entries[head].pc;
    assign head_flag   = entries[head].flag;
    assign head_ready  = entries[head].flag_ready;

endmodule

// File: rtl/ex_branch_scheduler.sv
// Branch scheduler top: in-order issue of queued branch ops to the branch port.
// Optional perf counters are enabled with the EX_BRANCH_SCHED_PERF_COUNTER_EN macro.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | issuing head op whenever its flags are ready
// ST_LOCKED | branch port locked; no issue, dispatch refused until restart
module ex_branch_scheduler
    import ex_branch_scheduler_pkg::*;
(
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iFREE_RESTART,
    input  logic        iDISP_VALID,
    input  logic [5:0]  iDISP_COMMIT_TAG,
    input  logic [4:0]  iDISP_CMD,
    input  logic [3:0]  iDISP_CC,
    input  logic [31:0] iDISP_SOURCE,
    input  logic [31:0] iDISP_PC,
    input  logic        iDISP_FLAG_READY,
    input  logic [4:0]  iDISP_FLAG,
    input  logic [5:0]  iDISP_FLAG_TAG,
    output logic        oDISP_FULL,
    input  logic        iFLAG_WB_VALID,
    input  logic [5:0]  iFLAG_WB_TAG,
    input  logic [4:0]  iFLAG_WB_FLAG,
    output logic        oEX_BRANCH_VALID,
    output logic [5:0]  oEX_BRANCH_COMMIT_TAG,
    output logic [4:0]  oEX_BRANCH_CMD,
    output logic [3:0]  oEX_BRANCH_CC,
    output logic [4:0]  oEX_BRANCH_FLAG,
    output logic [31:0] oEX_BRANCH_SOURCE,
    output logic [31:0] oEX_BRANCH_PC,
    input  logic        iEX_BRANCH_LOCK
`ifdef EX_BRANCH_SCHED_PERF_COUNTER_EN
    ,
    output logic [31:0] oPERF_ISSUE_CNT,
    output logic [31:0] oPERF_STALL_CNT
`endif
);

    sched_state_t     state;
    logic             queue_clear;
    logic             disp_accept;
    logic             issue;
    logic [CNT_W-1:0] q_count;
    logic [5:0]       head_tag;
    logic [4:0]       head_cmd;
    logic [3:0]       head_cc;
    logic [31:0]      head_source;
    logic [31:0]      head_pc;
    logic [4:0]       head_flag;
    logic             head_ready;

    // Restart wipes everything reset does; full is judged on current state
    // only, so a pop this cycle never opens a slot for a same-cycle dispatch
    assign queue_clear = iRESET_SYNC || iFREE_RESTART;
    assign oDISP_FULL  = (q_count == QUEUE_FULL_COUNT) || (state == ST_LOCKED);
    assign disp_accept = iDISP_VALID && !oDISP_FULL;
    assign issue       = (state == ST_RUN) && !iEX_BRANCH_LOCK &&
                         (q_count != '0) && head_ready;

    ex_branch_sched_queue u_queue (
        .clk             (iCLOCK),
        .clear           (queue_clear),
        .push            (disp_accept),
        .push_tag        (iDISP_COMMIT_TAG),
        .push_cmd        (iDISP_CMD),
        .push_cc         (iDISP_CC),
        .push_source     (iDISP_SOURCE),
        .push_pc         (iDISP_PC),
        .push_flag_ready (iDISP_FLAG_READY),
        .push_flag       (iDISP_FLAG),
        .push_flag_tag   (iDISP_FLAG_TAG),
        .pop             (issue),
        .wb_valid        (iFLAG_WB_VALID),
        .wb_tag          (iFLAG_WB_TAG),
        .wb_flag         (iFLAG_WB_FLAG),
        .count           (q_count),
        .head_tag        (head_tag),
        .head_cmd        (head_cmd),
        .head_cc         (head_cc),
        .head_source     (head_source),
        .head_pc         (head_pc),
        .head_flag       (head_flag),
        .head_ready      (head_ready)
    );

    // FSM and issue register; fields hold their last issued value while idle
    always_ff @(posedge iCLOCK) begin
        if (queue_clear) begin
            state                 <= ST_RUN;
            oEX_BRANCH_VALID      <= 1'b0;
            oEX_BRANCH_COMMIT_TAG <= '0;
            oEX_BRANCH_CMD        <= '0;
            oEX_BRANCH_CC         <= '0;
            oEX_BRANCH_FLAG       <= '0;
            oEX_BRANCH_SOURCE     <= '0;
            oEX_BRANCH_PC         <= '0;
        end else begin
            oEX_BRANCH_VALID <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (iEX_BRANCH_LOCK) begin
                        state <= ST_LOCKED;
                    end else if (issue) begin
                        oEX_BRANCH_VALID      <= 1'b1;
                        oEX_BRANCH_COMMIT_TAG <= head_tag;
                        oEX_BRANCH_CMD        <= head_cmd;
                        oEX_BRANCH_CC         <= head_cc;
                        oEX_BRANCH_FLAG       <= head_flag;
                        oEX_BRANCH_SOURCE     <= head_source;
                        oEX_BRANCH_PC         <= head_pc;
                    end
                end
                ST_LOCKED: begin
                    state <= ST_LOCKED;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef EX_BRANCH_SCHED_PERF_COUNTER_EN
    // Issue and stall counters, free-running with natural 32-bit wrap
    always_ff @(posedge iCLOCK) begin
        if (queue_clear) begin
            oPERF_ISSUE_CNT <= '0;
            oPERF_STALL_CNT <= '0;
        end else begin
            if (issue) begin
                oPERF_ISSUE_CNT <= oPERF_ISSUE_CNT + 32'd1;
            end
            if ((q_count != '0) && !issue) begin
                oPERF_STALL_CNT <= oPERF_STALL_CNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_branch_scheduler.sv
// Directed bench for ex_branch_scheduler: hand sequences for reset, wakeup,
// full/in-order, lock/restart and mid-op reset, then a cycle-by-cycle vector
// table for streaming, pointer wrap and same-cycle events.
module tb_ex_branch_scheduler;

    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC = 1'b0;
    logic        iFREE_RESTART = 1'b0;
    logic        iDISP_VALID = 1'b0;
    logic [5:0]  iDISP_COMMIT_TAG = '0;
    logic [4:0]  iDISP_CMD = '0;
    logic [3:0]  iDISP_CC = '0;
    logic [31:0] iDISP_SOURCE = '0;
    logic [31:0] iDISP_PC = '0;
    logic        iDISP_FLAG_READY = 1'b0;
    logic [4:0]  iDISP_FLAG = '0;
    logic [5:0]  iDISP_FLAG_TAG = '0;
    logic        oDISP_FULL;
    logic        iFLAG_WB_VALID = 1'b0;
    logic [5:0]  iFLAG_WB_TAG = '0;
    logic [4:0]  iFLAG_WB_FLAG = '0;
    logic        oEX_BRANCH_VALID;
    logic [5:0]  oEX_BRANCH_COMMIT_TAG;
    logic [4:0]  oEX_BRANCH_CMD;
    logic [3:0]  oEX_BRANCH_CC;
    logic [4:0]  oEX_BRANCH_FLAG;
    logic [31:0] oEX_BRANCH_SOURCE;
    logic [31:0] oEX_BRANCH_PC;
    logic        iEX_BRANCH_LOCK = 1'b0;
`ifdef EX_BRANCH_SCHED_PERF_COUNTER_EN
    logic [31:0] oPERF_ISSUE_CNT;
    logic [31:0] oPERF_STALL_CNT;
`endif

    int checks = 0;
    int errors = 0;

    always #5 iCLOCK = ~iCLOCK;

    ex_branch_scheduler dut (
        .iCLOCK                (iCLOCK),
        .iRESET_SYNC           (iRESET_SYNC),
        .iFREE_RESTART         (iFREE_RESTART),
        .iDISP_VALID           (iDISP_VALID),
        .iDISP_COMMIT_TAG      (iDISP_COMMIT_TAG),
        .iDISP_CMD             (iDISP_CMD),
        .iDISP_CC              (iDISP_CC),
        .iDISP_SOURCE          (iDISP_SOURCE),
        .iDISP_PC              (iDISP_PC),
        .iDISP_FLAG_READY      (iDISP_FLAG_READY),
        .iDISP_FLAG            (iDISP_FLAG),
        .iDISP_FLAG_TAG        (iDISP_FLAG_TAG),
        .oDISP_FULL            (oDISP_FULL),
        .iFLAG_WB_VALID        (iFLAG_WB_VALID),
        .iFLAG_WB_TAG          (iFLAG_WB_TAG),
        .iFLAG_WB_FLAG         (iFLAG_WB_FLAG),
        .oEX_BRANCH_VALID      (oEX_BRANCH_VALID),
        .oEX_BRANCH_COMMIT_TAG (oEX_BRANCH_COMMIT_TAG),
        .oEX_BRANCH_CMD        (oEX_BRANCH_CMD),
        .oEX_BRANCH_CC         (oEX_BRANCH_CC),
        .oEX_BRANCH_FLAG       (oEX_BRANCH_FLAG),
        .oEX_BRANCH_SOURCE     (oEX_BRANCH_SOURCE),
        .oEX_BRANCH_PC         (oEX_BRANCH_PC),
        .iEX_BRANCH_LOCK       (iEX_BRANCH_LOCK)
`ifdef EX_BRANCH_SCHED_PERF_COUNTER_EN
        ,
        .oPERF_ISSUE_CNT       (oPERF_ISSUE_CNT),
        .oPERF_STALL_CNT       (oPERF_STALL_CNT)
`endif
    );

    typedef struct {
        logic       restart;
        logic       disp;
        logic [5:0] tag;
        logic       ready;
        logic [4:0] flag;
        logic [5:0] ftag;
        logic       wb;
        logic [5:0] wb_tag;
        logic [4:0] wb_flag;
        logic       exp_valid;
        logic [5:0] exp_tag;
        logic [4:0] exp_flag;
        logic       exp_full;
    } vec_t;

    vec_t vecs[$];
    localparam int STREAM_ROWS = 12;

    // Stimulus payload is derived from the commit tag so issued fields are predictable
    function automatic logic [4:0] cmd_of(input logic [5:0] t);
        return t[4:0] ^ 5'h0B;
    endfunction
    function automatic logic [3:0] cc_of(input logic [5:0] t);
        return t[3:0];
    endfunction
    function automatic logic [31:0] src_of(input logic [5:0] t);
        return 32'hC0DE_0000 | {26'd0, t};
    endfunction
    function automatic logic [31:0] pc_of(input logic [5:0] t);
        return 32'h0000_4000 + {24'd0, t, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic idle_inputs();
        iFREE_RESTART    = 1'b0;
        iDISP_VALID      = 1'b0;
        iDISP_FLAG_READY = 1'b0;
        iFLAG_WB_VALID   = 1'b0;
        iEX_BRANCH_LOCK  = 1'b0;
    endtask

    task automatic drive_disp(input logic [5:0] t, input logic rdy,
                              input logic [4:0] fl, input logic [5:0] ft);
        iDISP_VALID      = 1'b1;
        iDISP_COMMIT_TAG = t;
        iDISP_CMD        = cmd_of(t);
        iDISP_CC         = cc_of(t);
        iDISP_SOURCE     = src_of(t);
        iDISP_PC         = pc_of(t);
        iDISP_FLAG_READY = rdy;
        iDISP_FLAG       = fl;
        iDISP_FLAG_TAG   = ft;
    endtask

    task automatic drive_wb(input logic [5:0] t, input logic [4:0] fl);
        iFLAG_WB_VALID = 1'b1;
        iFLAG_WB_TAG   = t;
        iFLAG_WB_FLAG  = fl;
    endtask

    task automatic expect_idle(input string name);
        chk({name, "_valid"}, 128'(oEX_BRANCH_VALID), 128'(1'b0));
    endtask

    task automatic expect_issue(input string name, input logic [5:0] t, input logic [4:0] fl);
        chk({name, "_valid"}, 128'(oEX_BRANCH_VALID), 128'(1'b1));
        chk({name, "_fields"},
            128'({oEX_BRANCH_COMMIT_TAG, oEX_BRANCH_CMD, oEX_BRANCH_CC, oEX_BRANCH_FLAG,
                  oEX_BRANCH_SOURCE, oEX_BRANCH_PC}),
            128'({t, cmd_of(t), cc_of(t), fl, src_of(t), pc_of(t)}));
    endtask

    task automatic add_vec(input logic rs, input logic d, input logic [5:0] tg, input logic rdy,
                           input logic [4:0] fl, input logic [5:0] ft, input logic w,
                           input logic [5:0] wt, input logic [4:0] wf, input logic ev,
                           input logic [5:0] et, input logic [4:0] ef, input logic efull);
        vec_t v;
        v.restart = rs;  v.disp = d;     v.tag = tg;      v.ready = rdy;
        v.flag = fl;     v.ftag = ft;    v.wb = w;        v.wb_tag = wt;
        v.wb_flag = wf;  v.exp_valid = ev; v.exp_tag = et; v.exp_flag = ef;
        v.exp_full = efull;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_issue;

        // Reset
        iRESET_SYNC = 1'b1;
        tick();
        tick();
        iRESET_SYNC = 1'b0;
        expect_idle("reset");
        chk("reset_full", 128'(oDISP_FULL), 128'(1'b0));
        chk("reset_fields",
            128'({oEX_BRANCH_COMMIT_TAG, oEX_BRANCH_CMD, oEX_BRANCH_CC, oEX_BRANCH_FLAG,
                  oEX_BRANCH_SOURCE, oEX_BRANCH_PC}), 128'(0));

        // Wakeup by later broadcast
        drive_disp(6'h05, 1'b0, 5'h00, 6'h12);
        tick();
        idle_inputs();
        expect_idle("wk_disp");
        tick();
        expect_idle("wk_wait");
        drive_wb(6'h12, 5'h01);
        tick();
        idle_inputs();
        expect_idle("wk_bcast");
        tick();
        expect_issue("wk_issue", 6'h05, 5'h01);
        tick();
        expect_idle("wk_after");

        // Full queue, in-order issue behind a blocked head
        drive_disp(6'h10, 1'b0, 5'h00, 6'h13);
        tick();
        expect_idle("full_d0");
        drive_disp(6'h11, 1'b1, 5'h1F, 6'h00);
        tick();
        drive_disp(6'h12, 1'b1, 5'h1F, 6'h00);
        tick();
        drive_disp(6'h13, 1'b1, 5'h1F, 6'h00);
        tick();
        expect_idle("full_noissue");
        chk("full_flag", 128'(oDISP_FULL), 128'(1'b1));
        drive_disp(6'h14, 1'b1, 5'h1F, 6'h00);
        tick();
        idle_inputs();
        expect_idle("full_5th");
        chk("full_still", 128'(oDISP_FULL), 128'(1'b1));
        drive_wb(6'h13, 5'h02);
        tick();
        idle_inputs();
        expect_idle("full_wake");
        tick();
        expect_issue("full_i0", 6'h10, 5'h02);
        chk("full_freed", 128'(oDISP_FULL), 128'(1'b0));
        tick();
        expect_issue("full_i1", 6'h11, 5'h1F);
        tick();
        expect_issue("full_i2", 6'h12, 5'h1F);
        tick();
        expect_issue("full_i3", 6'h13, 5'h1F);
        tick();
        expect_idle("full_refused");

        // Lock then restart
        drive_disp(6'h21, 1'b1, 5'h04, 6'h00);
        tick();
        expect_idle("lk_d0");
        drive_disp(6'h22, 1'b1, 5'h05, 6'h00);
        tick();
        idle_inputs();
        expect_issue("lk_i0", 6'h21, 5'h04);
        iEX_BRANCH_LOCK = 1'b1;
        tick();
        iEX_BRANCH_LOCK = 1'b0;
        expect_idle("lk_noissue");
        chk("lk_full", 128'(oDISP_FULL), 128'(1'b1));
        tick();
        expect_idle("lk_hold");
        chk("lk_full_hold", 128'(oDISP_FULL), 128'(1'b1));
        iFREE_RESTART = 1'b1;
        tick();
        iFREE_RESTART = 1'b0;
        expect_idle("rs_valid");
        chk("rs_full", 128'(oDISP_FULL), 128'(1'b0));
        tick();
        expect_idle("rs_empty");
        drive_disp(6'h23, 1'b1, 5'h06, 6'h00);
        tick();
        idle_inputs();
        expect_idle("rs_d0");
        tick();
        expect_issue("rs_run", 6'h23, 5'h06);

        // Reset mid-operation discards a waiting entry
        drive_disp(6'h25, 1'b0, 5'h00, 6'h30);
        tick();
        idle_inputs();
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        chk("mr_full", 128'(oDISP_FULL), 128'(1'b0));
        drive_wb(6'h30, 5'h07);
        tick();
        idle_inputs();
        tick();
        expect_idle("mr_discard");

        // Vector table: stream of 10 ready ops (wraps pointers), then corner cases
        for (int i = 0; i < 10; i++) begin
            add_vec(1'b0, 1'b1, 6'h30 + 6'(i), 1'b1, 5'(i + 1), 6'h00, 1'b0, 6'h00, 5'h00,
                    (i > 0), (i > 0) ? 6'h30 + 6'(i - 1) : 6'h00, 5'(i), 1'b0);
        end
        add_vec(0, 0, 6'h00, 0, 5'h00, 6'h00, 0, 6'h00, 5'h00, 1, 6'h39, 5'd10, 0);
        add_vec(0, 0, 6'h00, 0, 5'h00, 6'h00, 0, 6'h00, 5'h00, 0, 6'h00, 5'h00, 0);
        add_vec(0, 1, 6'h07, 0, 5'h00, 6'h20, 1, 6'h20, 5'h0A, 0, 6'h00, 5'h00, 0);
        add_vec(0, 0, 6'h00, 0, 5'h00, 6'h00, 0, 6'h00, 5'h00, 1, 6'h07, 5'h0A, 0);
        add_vec(0, 0, 6'h00, 0, 5'h00, 6'h00, 0, 6'h00, 5'h00, 0, 6'h00, 5'h00, 0);
        add_vec(1, 1, 6'h08, 1, 5'h03, 6'h00, 0, 6'h00, 5'h00, 0, 6'h00, 5'h00, 0);
        add_vec(0, 0, 6'h00, 0, 5'h00, 6'h00, 0, 6'h00, 5'h00, 0, 6'h00, 5'h00, 0);
        add_vec(0, 0, 6'h00, 0, 5'h00, 6'h00, 0, 6'h00, 5'h00, 0, 6'h00, 5'h00, 0);
        add_vec(0, 1, 6'h09, 0, 5'h00, 6'h11, 1, 6'h12, 5'h1F, 0, 6'h00, 5'h00, 0);
        add_vec(0, 0, 6'h00, 0, 5'h00, 6'h00, 1, 6'h11, 5'h03, 0, 6'h00, 5'h00, 0);
        add_vec(0, 0, 6'h00, 0, 5'h00, 6'h00, 0, 6'h00, 5'h00, 1, 6'h09, 5'h03, 0);
        add_vec(0, 0, 6'h00, 0, 5'h00, 6'h00, 0, 6'h00, 5'h00, 0, 6'h00, 5'h00, 0);

        exp_issue = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].disp) begin
                drive_disp(vecs[i].tag, vecs[i].ready, vecs[i].flag, vecs[i].ftag);
            end
            if (vecs[i].wb) begin
                drive_wb(vecs[i].wb_tag, vecs[i].wb_flag);
            end
            iFREE_RESTART = vecs[i].restart;
            tick();
            idle_inputs();
            if (vecs[i].restart) begin
                exp_issue = 0;
            end else if (vecs[i].exp_valid) begin
                exp_issue++;
            end
            if (vecs[i].exp_valid) begin
                expect_issue($sformatf("vec%0d", i), vecs[i].exp_tag, vecs[i].exp_flag);
            end else begin
                expect_idle($sformatf("vec%0d", i));
            end
            chk($sformatf("vec%0d_full", i), 128'(oDISP_FULL), 128'(vecs[i].exp_full));
`ifdef EX_BRANCH_SCHED_PERF_COUNTER_EN
            if (i == STREAM_ROWS - 1) begin
                chk("perf_issue_stream", 128'(oPERF_ISSUE_CNT), 128'(exp_issue));
            end
`endif
        end
`ifdef EX_BRANCH_SCHED_PERF_COUNTER_EN
        chk("perf_issue_end", 128'(oPERF_ISSUE_CNT), 128'(exp_issue));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
